// File: rtl/mem_port_arbiter.sv
// Shared memory/IO port arbiter for the MIPS32 core.
// Serves the instruction-fetch requester and the data (load/store) requester
// one access at a time. Data normally wins; after STARVE_MAX consecutive data
// grants made while a fetch was waiting, the fetch is forced through. Each
// access is a single m_ce strobe followed by MEM_LAT wait cycles and a
// one-cycle ack to the owning requester.
module mem_port_arbiter #(
   parameter int          MEM_LAT    = 2,
   parameter int          STARVE_MAX = 4,
   parameter logic [15:0] IO_BASE    = 16'hBFD0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic [3:0]  d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        m_ce,
   output logic [3:0]  m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   output logic        io_sel,
   output logic        stall,
   output logic        busy
);

   localparam logic [2:0] LP_LAT    = 3'(MEM_LAT);
   localparam logic [3:0] LP_STARVE = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_gnt;       // 0 = instruction owns the port, 1 = data
   logic [3:0]  r_starve;
   logic [2:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_we;
   logic [31:0] r_irdata;
   logic [31:0] r_drdata;

   logic        w_any_req;
   logic        w_starved;
   logic        w_pick_data;
   logic        w_capture;

   assign w_any_req   = i_req | d_req;
   // A waiting fetch that has already watched STARVE_MAX data grants go by
   // takes precedence over data.
   assign w_starved   = i_req && (r_starve == LP_STARVE);
   assign w_pick_data = d_req && !w_starved;
   // Memory data is valid only in the last wait cycle.
   assign w_capture   = (r_state == ST_WAIT) && (r_cnt == 3'd1);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic: one access is IDLE -> ISSUE -> WAIT* -> DONE -> IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_any_req) w_state_nxt = ST_ISSUE;
         ST_ISSUE: w_state_nxt = ST_WAIT;
         ST_WAIT:  if (r_cnt == 3'd1) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Grant decision and latching of the winning request's address/we/wdata.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_gnt   <= 1'b0;
         r_addr  <= 32'd0;
         r_we    <= 4'd0;
         r_wdata <= 32'd0;
      end else if ((r_state == ST_IDLE) && w_any_req) begin
         r_gnt  <= w_pick_data;
         r_addr <= w_pick_data ? d_addr : i_addr;
         r_we   <= w_pick_data ? d_we : 4'd0;
         if (w_pick_data) r_wdata <= d_wdata;
      end
   end

   // Starvation counter: counts data grants that bypassed a pending fetch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_starve <= 4'd0;
      end else if (r_state == ST_IDLE) begin
         if (!i_req || !w_pick_data)    r_starve <= 4'd0;
         else if (r_starve != LP_STARVE) r_starve <= r_starve + 4'd1;
      end
   end

   // Memory latency counter, loaded in ISSUE and run down through WAIT.
   always_ff @(posedge clk) begin
      if (!rst_n)                   r_cnt <= 3'd0;
      else if (r_state == ST_ISSUE) r_cnt <= LP_LAT;
      else if (r_state == ST_WAIT)  r_cnt <= r_cnt - 3'd1;
   end

   // Read data return; stores leave the load data register untouched.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_irdata <= 32'd0;
         r_drdata <= 32'd0;
      end else if (w_capture) begin
         if (!r_gnt)               r_irdata <= m_rdata;
         else if (r_we == 4'd0)    r_drdata <= m_rdata;
      end
   end

   assign m_ce    = (r_state == ST_ISSUE);
   assign m_we    = m_ce ? r_we : 4'd0;
   assign m_addr  = r_addr;
   assign m_wdata = r_wdata;
   assign i_ack   = (r_state == ST_DONE) && !r_gnt;
   assign d_ack   = (r_state == ST_DONE) &&  r_gnt;
   assign i_rdata = r_irdata;
   assign d_rdata = r_drdata;
   assign busy    = (r_state != ST_IDLE);
   assign io_sel  = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && r_gnt &&
                    (r_addr[31:16] == IO_BASE);
   assign stall   = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port memory/IO port between the instruction-fetch requester and the data (load/store) requester of the MIPS32 core. Sits between the pipeline and the device-interface layer: it accepts req/ack transactions from both sides, chooses one by fixed priority with anti-starvation, issues a one-cycle memory access, waits a configurable latency, returns read data and raises a stall to the pipeline while any request is outstanding.

## Interface
- MEM_LAT, 2, cycles from the m_ce cycle to valid m_rdata; legal 1..7
- STARVE_MAX, 4, consecutive data grants allowed while i_req is pending before instruction is forced; legal 1..15
- IO_BASE, 16'hBFD0, upper address half selecting the IO space

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_req  in  1  instruction fetch request; held with i_addr stable until i_ack
- i_addr  in  32  fetch address
- i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  32  fetched word, held until next i_ack
- d_req  in  1  data request; held with d_addr/d_we/d_wdata stable until d_ack
- d_we  in  4  byte write enables; 4'b0000 = read
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  32  load data, updated only by reads, held otherwise
- m_ce  out  1  memory access strobe, high exactly one cycle per access
- m_we  out  4  byte enables during m_ce; 0 for fetches and outside m_ce
- m_addr  out  32  latched access address
- m_wdata  out  32  latched store data
- m_rdata  in  32  memory/IO read data, valid in the MEM_LAT-th cycle after m_ce
- io_sel  out  1  high in ISSUE/WAIT of a data access with m_addr[31:16]==IO_BASE
- stall  out  1  (i_req & ~i_ack) | (d_req & ~d_ack), combinational
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Owner register gnt (0=instr, 1=data).
- IDLE: no request -> stay. Otherwise pick owner, latch address/we/wdata into m_addr/m_we/m_wdata (m_we forced 0 for instr), -> ISSUE.
- Arbitration: data wins over instruction, except when starve_cnt == STARVE_MAX and i_req high, then instruction wins.
- starve_cnt (4 bits): +1 on each data grant made while i_req high; cleared on any instruction grant or any IDLE arbitration with i_req low; saturates at STARVE_MAX.
- ISSUE: m_ce=1, m_we=latched we; load wait counter with MEM_LAT; -> WAIT.
- WAIT: m_ce=0, m_we=0; decrement counter; when counter==1, capture m_rdata into i_rdata (instr) or d_rdata (data read; writes leave d_rdata unchanged); -> DONE.
- DONE: assert i_ack or d_ack per gnt for this cycle only; requests ignored; -> IDLE.
- m_addr/m_wdata hold last latched values outside transactions.
- io_sel derived from latched address and gnt; 0 for fetches.

## Timing
- Request seen in IDLE at cycle 0 -> ISSUE (m_ce) cycle 1 -> WAIT cycles 2..MEM_LAT+1 -> ack in cycle MEM_LAT+2 -> IDLE cycle MEM_LAT+3.
- m_rdata sampled at end of cycle MEM_LAT+1; ack and rdata visible together in DONE.
- Throughput: one access per MEM_LAT+3 cycles; back-to-back requests accepted in the IDLE cycle after DONE.
- Requester must drop or change req only after observing ack; arbiter does not check stability.
- Simultaneous i_req and d_req in IDLE: data granted unless starvation rule applies; loser keeps stall high.
- Reset (rst_n low at an edge): state IDLE, gnt 0, counters 0; all outputs 0 (i_ack, d_ack, m_ce, m_we, m_addr, m_wdata, i_rdata, d_rdata, io_sel, busy) from next cycle. Mid-transaction reset abandons the access: no ack is issued, m_ce never re-asserts for it.
- stall follows inputs combinationally, including during reset.

## Test plan
- Single fetch, MEM_LAT=2: i_req=1, i_addr=0xBFC00000 at cycle 0, memory returns 0x3C080001 in cycle 3 -> m_ce only in cycle 1 with m_addr=0xBFC00000, m_we=0, i_ack and i_rdata=0x3C080001 in cycle 4, stall high cycles 0-3.
- Store to IO: d_req, d_we=4'b1111, d_addr=0xBFD0F000, d_wdata=0x000000FF -> cycle 1 m_ce=1, m_we=4'hF, io_sel=1 cycles 1-3, d_ack cycle 4, d_rdata unchanged.
- Simultaneous i_req and d_req (RAM read 0x00001000) -> data granted first, d_ack cycle 4, instruction ISSUE at cycle 6, i_ack cycle 9.
- Starvation, STARVE_MAX=4: d_req and i_req held continuously -> four data grants, fifth grant instruction, then data resumes.
- MEM_LAT=1 and MEM_LAT=7: single read each -> ack in cycle 3 and cycle 9 respectively, data captured from the last WAIT cycle only.
- Reset in WAIT: rst_n low one cycle during cycle 2 -> no ack, all outputs 0 in cycle 3, new request at cycle 4 served normally.
